// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types and default 640x480@60 timing for the VGA timing controller.
//   vga_phase_t : per-axis raster region (sync, back porch, active, front porch)
//   DEF_*       : default divider and per-axis region lengths
//   DEF_*_TOTAL : line / frame length derived as the sum of the regions
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    ACTIVE      = 2'd2,
    FRONT_PORCH = 2'd3
  } vga_phase_t;

  localparam int DEF_CLK_DIV  = 2;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;

  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam int DEF_H_TOTAL  = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_V_TOTAL  = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Raster timing bundle from the timing controller to the pixel generator.
//   hcount/vcount : current pixel position
//   hsync/vsync   : active-low sync pulses for the VGA connector
//   bright        : visible region
//   pix_en        : last system clock of each pixel period
//   frame_start   : one-clock pulse at the end of the last pixel of a frame
//   leds          : LED pattern for the pixel generator
//   Modports: master (controller drives), slave (pixel generator samples).
interface vga_timing_if;

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       bright;
  logic       pix_en;
  logic       frame_start;
  logic [5:0] leds;

  modport master (
    output hcount, vcount, hsync, vsync, bright, pix_en, frame_start, leds
  );

  modport slave (
    input hcount, vcount, hsync, vsync, bright, pix_en, frame_start, leds
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: a position counter that wraps at SYNC+BP+ACTIVE+FP and a
//   phase FSM that tracks which region the count is in.
//   clk_i    system clock
//   rst_i    synchronous active-high reset (count 0, phase SYNC)
//   step_i   advance one position this edge
//   count_o  current position
//   phase_o  current region
//   wrap_o   count is at its last position (next step wraps to 0)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int FP     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [9:0] count_o,
  output vga_phase_t phase_o,
  output logic       wrap_o
);

  localparam int         TOTAL = SYNC + BP + ACTIVE + FP;
  localparam logic [9:0] LAST  = 10'(TOTAL - 1);
  localparam logic [9:0] B_BP  = 10'(SYNC);
  localparam logic [9:0] B_ACT = 10'(SYNC + BP);
  localparam logic [9:0] B_FP  = 10'(SYNC + BP + ACTIVE);

  logic [9:0] count_q;
  logic [9:0] count_d;
  vga_phase_t phase_q;
  vga_phase_t phase_d;

  // Next position and region, decoded from the count the axis moves onto
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step_i) begin
      if (count_q == LAST) begin
        count_d = 10'd0;
        phase_d = vga_timing_pkg::SYNC;
      end else begin
        count_d = count_q + 10'd1;
        case (phase_q)
          vga_timing_pkg::SYNC: begin
            if (count_d == B_BP) phase_d = vga_timing_pkg::BACK_PORCH;
            else                 phase_d = phase_q;
          end
          vga_timing_pkg::BACK_PORCH: begin
            if (count_d == B_ACT) phase_d = vga_timing_pkg::ACTIVE;
            else                  phase_d = phase_q;
          end
          vga_timing_pkg::ACTIVE: begin
            if (count_d == B_FP) phase_d = vga_timing_pkg::FRONT_PORCH;
            else                 phase_d = phase_q;
          end
          vga_timing_pkg::FRONT_PORCH: begin
            // leaving the front porch only happens through the wrap above
            phase_d = phase_q;
          end
          default: begin
            phase_d = vga_timing_pkg::SYNC;
          end
        endcase
      end
    end else begin
      count_d = count_q;
      phase_d = phase_q;
    end
  end

  // Position and region registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 10'd0;
      phase_q <= vga_timing_pkg::SYNC;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign wrap_o  = (count_q == LAST);

endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//   Free-running 640x480@60 raster timing for the LED-box pixel generator.
//   clk        system clock
//   rst        synchronous active-high reset
//   leds_in_i  raw LED pattern from the switch/counter logic
//   vga_o      timing bundle (vga_timing_if.master): counts, syncs, bright,
//              pix_en, frame_start and the LED copy for the pixel generator
//   Build option VGA_FRAME_LATCH_EN: when defined the LED copy only reloads on
//   frame_start, so a frame never shows two patterns; otherwise it follows
//   leds_in_i with one clock of latency.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   leds_in_i,
  vga_timing_if.master vga_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [5:0]       leds_q;
  logic [5:0]       leds_d;

  logic             pix_en_s;
  logic             v_step_s;
  logic             frame_start_s;
  logic [9:0]       h_count_s;
  logic [9:0]       v_count_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  vga_phase_t       h_phase_s;
  vga_phase_t       v_phase_s;

  // Pixel divider next state: count 0..CLK_DIV-1 and wrap
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Pixel divider register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // With CLK_DIV==1 DIV_LAST is 0, so pix_en stays high including right after reset
  assign pix_en_s = (div_cnt_q == DIV_LAST);
  assign v_step_s = pix_en_s & h_wrap_s;

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP)
  ) u_h_axis (
    .clk_i   (clk),
    .rst_i   (rst),
    .step_i  (pix_en_s),
    .count_o (h_count_s),
    .phase_o (h_phase_s),
    .wrap_o  (h_wrap_s)
  );

  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP)
  ) u_v_axis (
    .clk_i   (clk),
    .rst_i   (rst),
    .step_i  (v_step_s),
    .count_o (v_count_s),
    .phase_o (v_phase_s),
    .wrap_o  (v_wrap_s)
  );

  assign frame_start_s = pix_en_s & h_wrap_s & v_wrap_s;

  // LED copy next state
  always_comb begin
    leds_d = leds_q;
`ifdef VGA_FRAME_LATCH_EN
    if (frame_start_s) begin
      leds_d = leds_in_i;
    end else begin
      leds_d = leds_q;
    end
`else
    leds_d = leds_in_i;
`endif
  end

  // LED copy register
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= 6'd0;
    end else begin
      leds_q <= leds_d;
    end
  end

  // Decodes come straight from registered state, so they line up with the counts
  assign vga_o.hcount      = h_count_s;
  assign vga_o.vcount      = v_count_s;
  assign vga_o.hsync       = (h_phase_s != SYNC);
  assign vga_o.vsync       = (v_phase_s != SYNC);
  assign vga_o.bright      = (h_phase_s == ACTIVE) & (v_phase_s == ACTIVE);
  assign vga_o.pix_en      = pix_en_s;
  assign vga_o.frame_start = frame_start_s;
  assign vga_o.leds        = leds_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller
//   Three controllers share clock, reset and LED input:
//   0: compact raster (H 4/3/8/2, V 2/3/5/2), CLK_DIV=2 -> 408 clks per frame
//   1: same compact raster, CLK_DIV=1              -> 204 clks per frame
//   2: full 640x480 timing, CLK_DIV=2 (first lines only)
//   Each edge the model pushes the expected outputs to a per-instance queue;
//   the values are popped and compared on the following falling edge.
module tb_vga_timing_controller;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       pe;
    logic       fs;
    logic [5:0] leds;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] leds_in = 6'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int unsigned t_m[3];
  logic [5:0]  led_m[3];
  int          last_fs[3];
  int          fs_seen_a = 0;
  int          fs_model_a = 0;

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  vga_timing_if if_a ();
  vga_timing_if if_b ();
  vga_timing_if if_d ();

  vga_timing_controller #(
    .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(5), .V_FP(2)
  ) dut_a (.clk(clk), .rst(rst), .leds_in_i(leds_in), .vga_o(if_a));

  vga_timing_controller #(
    .CLK_DIV(1), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(5), .V_FP(2)
  ) dut_b (.clk(clk), .rst(rst), .leds_in_i(leds_in), .vga_o(if_b));

  vga_timing_controller dut_d (.clk(clk), .rst(rst), .leds_in_i(leds_in), .vga_o(if_d));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference raster: position derived arithmetically from clocks since reset
  function automatic obs_t model(input int k, input int unsigned t);
    obs_t m;
    int cd, hs, hb, ha, hf, vs, vb, va, vf, ht, vt, p, h, v;
    if (k == 2) begin
      cd = 2; hs = 96; hb = 48; ha = 640; hf = 16; vs = 2; vb = 33; va = 480; vf = 10;
    end else begin
      cd = (k == 0) ? 2 : 1;
      hs = 4; hb = 3; ha = 8; hf = 2; vs = 2; vb = 3; va = 5; vf = 2;
    end
    ht = hs + hb + ha + hf;
    vt = vs + vb + va + vf;
    p  = int'(t) / cd;
    h  = p % ht;
    v  = (p / ht) % vt;
    m.h    = 10'(h);
    m.v    = 10'(v);
    m.hs   = (h >= hs);
    m.vs   = (v >= vs);
    m.br   = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    m.pe   = ((int'(t) % cd) == cd - 1);
    m.fs   = m.pe && (h == ht - 1) && (v == vt - 1);
    m.leds = 6'd0;
    return m;
  endfunction

  function automatic obs_t sample(input int k);
    obs_t s;
    if (k == 0) begin
      s = {if_a.hcount, if_a.vcount, if_a.hsync, if_a.vsync, if_a.bright,
           if_a.pix_en, if_a.frame_start, if_a.leds};
    end else if (k == 1) begin
      s = {if_b.hcount, if_b.vcount, if_b.hsync, if_b.vsync, if_b.bright,
           if_b.pix_en, if_b.frame_start, if_b.leds};
    end else begin
      s = {if_d.hcount, if_d.vcount, if_d.hsync, if_d.vsync, if_d.bright,
           if_d.pix_en, if_d.frame_start, if_d.leds};
    end
    return s;
  endfunction

  task automatic compare(input int k, input obs_t e);
    obs_t  o;
    string sfx;
    o   = sample(k);
    sfx = $sformatf("[%0d]", k);
    check_val({"hcount", sfx}, 32'(o.h), 32'(e.h));
    check_val({"vcount", sfx}, 32'(o.v), 32'(e.v));
    check_val({"hsync", sfx}, 32'(o.hs), 32'(e.hs));
    check_val({"vsync", sfx}, 32'(o.vs), 32'(e.vs));
    check_val({"bright", sfx}, 32'(o.br), 32'(e.br));
    check_val({"pix_en", sfx}, 32'(o.pe), 32'(e.pe));
    check_val({"frame_start", sfx}, 32'(o.fs), 32'(e.fs));
    check_val({"leds_out", sfx}, 32'(o.leds), 32'(e.leds));
    // frame period measured on the DUT's own strobe
    if (k < 2 && o.fs === 1'b1) begin
      if (k == 0) fs_seen_a++;
      if (last_fs[k] >= 0) begin
        check_val({"fs_period", sfx}, 32'(cyc - last_fs[k]), (k == 0) ? 32'd408 : 32'd204);
      end
      last_fs[k] = cyc;
    end
    // full-timing horizontal boundaries
    if (k == 2) begin
      if (o.h == 10'd95)  check_val("hsync_at_95", 32'(o.hs), 32'd0);
      if (o.h == 10'd96)  check_val("hsync_at_96", 32'(o.hs), 32'd1);
      if (o.h == 10'd144) check_val("bright_top_rows", 32'(o.br), 32'd0);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic [5:0] l);
    obs_t pre;
    obs_t e;
    rst     = r;
    leds_in = l;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      pre = model(k, t_m[k]);
      if (r) begin
        t_m[k]     = 0;
        led_m[k]   = 6'd0;
        last_fs[k] = -1;
      end else begin
`ifdef VGA_FRAME_LATCH_EN
        if (pre.fs) led_m[k] = l;
`else
        led_m[k] = l;
`endif
        t_m[k] = t_m[k] + 1;
      end
      e      = model(k, t_m[k]);
      e.leds = led_m[k];
      if (k == 0 && e.fs) fs_model_a++;
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    @(negedge clk);
    compare(0, q0.pop_front());
    compare(1, q1.pop_front());
    compare(2, q2.pop_front());
  endtask

  initial begin
    logic [5:0] l;
    for (int k = 0; k < 3; k++) begin
      t_m[k]     = 0;
      led_m[k]   = 6'd0;
      last_fs[k] = -1;
    end
    drive_cycle(1'b1, 6'd0);
    drive_cycle(1'b1, 6'd0);
    for (int i = 0; i < 4000; i++) begin
      if (i < 1000)      l = 6'b000000;
      else if (i < 2500) l = 6'b101010;
      else if (i < 3300) l = 6'b010101;
      else               l = 6'(i);
      // reset lands mid-line on the full-timing instance (hcount 500)
      drive_cycle(i == 2600, l);
    end
    check_val("fs_count_a", 32'(fs_seen_a), 32'(fs_model_a));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
